// File: rtl/seq_rbs.sv
// seq_rbs: multi-cycle ripple-borrow subtractor.
// Resolves `chunk` bits of op1 - op2 - bin per clock, carrying the borrow in a
// register between chunks, with valid/ready handshakes on input and output.
module seq_rbs #(
    parameter int width = 16,
    parameter int chunk = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] op1,
    input  logic [width-1:0] op2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = width / chunk;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [width-1:0] a_reg, b_reg;
    logic [width-1:0] partial_reg, partial_next;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;

    logic [width-1:0] diff_reg;
    logic             bout_reg, ovf_reg, out_valid_reg;

    logic [chunk-1:0] a_chunks [N];
    logic [chunk-1:0] b_chunks [N];
    logic [chunk-1:0] a_cur, b_cur, chunk_diff;
    logic             chunk_bout;
    logic             borrow_chain;
    logic             ovf_calc;

    // Slice the latched operands into chunks and splice the freshly resolved
    // chunk into the partial result at the current chunk position.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chunk
            assign a_chunks[gi] = a_reg[gi*chunk +: chunk];
            assign b_chunks[gi] = b_reg[gi*chunk +: chunk];
            assign partial_next[gi*chunk +: chunk] =
                (cnt_reg == CW'(gi)) ? chunk_diff : partial_reg[gi*chunk +: chunk];
        end
    endgenerate

    assign a_cur = a_chunks[cnt_reg];
    assign b_cur = b_chunks[cnt_reg];

    // Ripple-borrow subtract of one chunk, seeded by the registered borrow.
    always_comb begin
        chunk_diff   = '0;
        borrow_chain = borrow_reg;
        for (int i = 0; i < chunk; i++) begin
            chunk_diff[i] = a_cur[i] ^ b_cur[i] ^ borrow_chain;
            borrow_chain  = (~a_cur[i] & b_cur[i]) |
                            (~(a_cur[i] ^ b_cur[i]) & borrow_chain);
        end
        chunk_bout = borrow_chain;
    end

    // Signed overflow: operands of differing sign and a result whose sign
    // disagrees with the minuend. Only sampled on the final chunk, when the
    // top bit of partial_next is the true result sign.
    assign ovf_calc = (a_reg[width-1] != b_reg[width-1]) &
                      (partial_next[width-1] != a_reg[width-1]);

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)          state_next = CALC;
            CALC:    if (cnt_reg == LAST)   state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // State register plus the datapath registers that advance with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            partial_reg <= '0;
            borrow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= op1;
                        b_reg       <= op2;
                        borrow_reg  <= bin;
                        cnt_reg     <= '0;
                        partial_reg <= '0;
                    end
                end
                CALC: begin
                    partial_reg <= partial_next;
                    borrow_reg  <= chunk_bout;
                    cnt_reg     <= cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: only written on the last chunk, so partial values
    // never reach the outputs; they hold through DONE and the next CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_reg      <= '0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (state_reg == CALC && cnt_reg == LAST) begin
                diff_reg      <= partial_next;
                bout_reg      <= chunk_bout;
                ovf_reg       <= ovf_calc;
                out_valid_reg <= 1'b1;
            end else if (state_reg == DONE && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_reg == IDLE) & ~rst;
    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_rbs.sv
// tb_seq_rbs: randomized and directed checks of seq_rbs against an
// arithmetic reference model with a per-cycle compare process.
module tb_seq_rbs;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1, op2;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    seq_rbs #(.width(W), .chunk(C)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {diff, bout, ovf} from plain integer arithmetic.
    function automatic logic [W+1:0] exp_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic c);
        logic [W:0] u;
        int         s;
        u = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        s = int'($signed(a)) - int'($signed(b)) - int'(c);
        return {u[W-1:0], u[W], (s > 32767 || s < -32768)};
    endfunction

    // Cycle-level model: idle / busy for N edges / holding result.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W+1:0] m_res   = '0;
    logic [W-1:0] m_diff  = '0;
    logic         m_bout  = 1'b0;
    logic         m_ovf   = 1'b0;

    // Compare every cycle on the falling edge, then advance the model to the next edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_in_ready",  in_ready,  (m_phase == 0 && !rst));
            chk("cyc_out_valid", out_valid, (m_phase == 2));
            chk("cyc_diff",      diff,      m_diff);
            chk("cyc_bout",      bout,      m_bout);
            chk("cyc_ovf",       ovf,       m_ovf);
            if (rst) begin
                m_phase = 0;
                m_diff  = '0;
                m_bout  = 1'b0;
                m_ovf   = 1'b0;
            end else begin
                case (m_phase)
                    0: if (in_valid) begin
                        m_res   = exp_calc(op1, op2, bin);
                        m_left  = N;
                        m_phase = 1;
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            {m_diff, m_bout, m_ovf} = m_res;
                            m_phase = 2;
                        end
                    end
                    default: if (out_ready) m_phase = 0;
                endcase
            end
        end
    end

    // One transaction with literal expectations; hold = back-pressure cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input int hold);
        int wait_cnt;
        int lat;
        out_ready = (hold == 0);
        op1 = a; op2 = b; bin = c; in_valid = 1'b1;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            @(posedge clk); #1; wait_cnt++;
        end
        chk("accept_wait", (wait_cnt < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1 = W'($urandom); op2 = W'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, N);
        chk("diff", diff, ed);
        chk("bout", bout, eb);
        chk("ovf", ovf, eo);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            op1 = W'($urandom); op2 = W'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff", diff, ed);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("xfer_out_valid", out_valid, 0);
        chk("xfer_in_ready", in_ready, 1);
        $display("op %h - %h - %0d -> diff=%h bout=%0d ovf=%0d lat=%0d hold=%0d",
                 a, b, c, diff, bout, ovf, lat, hold);
    endtask

    initial begin
        logic [W+1:0] r;
        logic [W-1:0] a, b;
        logic         c;

        // Pin the reference model itself.
        chk("model_basic", exp_calc(16'h1234, 16'h0234, 1'b0), {16'h1000, 1'b0, 1'b0});
        chk("model_wrap",  exp_calc(16'h0000, 16'h0001, 1'b0), {16'hFFFF, 1'b1, 1'b0});
        chk("model_ovf",   exp_calc(16'h7FFF, 16'hFFFF, 1'b0), {16'h8000, 1'b1, 1'b1});

        // Reset held 3 cycles with in_valid asserted.
        rst = 1'b1; in_valid = 1'b1; op1 = 16'h5555; op2 = 16'h1111; bin = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_diff", diff, 0);
            chk("rst_bout", bout, 0);
            chk("rst_ovf", ovf, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rel_no_accept", in_ready, 1);
        $display("reset sequence done");

        // Directed cases.
        do_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
        do_op(16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
        do_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0);
        do_op(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 6);

        // Reset on E2 of a CALC.
        op1 = 16'h4321; op2 = 16'h0123; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;           // E0: accepted
        in_valid = 1'b0;
        @(posedge clk); #1;           // E1
        rst = 1'b1;
        @(posedge clk); #1;           // E2 under reset
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_diff", diff, 0);
        end
        $display("mid-operation reset done");
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Randomized operations with occasional boundary operands.
        for (int t = 0; t < 40; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: b = 16'hFFFF;
                2: a = 16'h7FFF;
                3: b = a;
                default: ;
            endcase
            r = exp_calc(a, b, c);
            do_op(a, b, c, r[W+1:2], r[1], r[0], int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
